// File: rtl/seq_div_pkg.sv
// Package for the sequential approximate divider.
// Contents:
//   state_t      FSM states {IDLE, BUSY, DONE}
//   exact_bout   borrow-out of an exact restoring-subtractor cell
//   exact_rout   remainder-out of an exact cell (selected by qs)
//   approx_bout  borrow-out of the approximate cell
//   approx_rout  remainder-out of the approximate cell
//   approx_mask  low-bit mask of approximate cells for a given iteration
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic exact_bout(input logic a, input logic b, input logic bin);
    return (~a & bin) | (~a & b) | (b & bin);
  endfunction

  function automatic logic exact_rout(input logic a, input logic b, input logic bin,
                                      input logic qs);
    return qs ? (a ^ b ^ bin) : a;
  endfunction

  function automatic logic approx_bout(input logic a, input logic b, input logic bin);
    return bin & (b | ~a);
  endfunction

  function automatic logic approx_rout(input logic a, input logic b, input logic bin,
                                       input logic qs);
    return a | (qs & (b ^ bin));
  endfunction

  // Number of approximate LSB cells grows by one per iteration over the
  // last 'stages' iterations, clamped to [0, dw].
  function automatic logic [31:0] approx_mask(input int unsigned i, input int unsigned dw,
                                              input int unsigned stages);
    logic [31:0] m;
    int          k;
    m = '0;
    k = int'(i) - (int'(dw) - int'(stages)) + 1;
    if (k < 0) k = 0;
    if (k > int'(dw)) k = int'(dw);
    for (int unsigned b = 0; b < 32; b++) begin
      if (int'(b) < k) m[b] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_div_row.sv
// Single combinational row of the restoring divider.
// Ports:
//   x     in  DW+1  partial remainder (x[DW] is the bit shifted out last time)
//   y     in  DW    divisor
//   mask  in  DW    1 = use approximate cell at that bit position
//   qs    out 1     quotient bit / restore select
//   rout  out DW    next partial remainder (before the new dividend bit)
module seq_div_row
  import seq_div_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW:0]   x,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] mask,
  output logic          qs,
  output logic [DW-1:0] rout
);

  logic [DW:0] borrow;

  always_comb begin
    borrow = '0;
    rout   = '0;
    for (int unsigned j = 0; j < DW; j++) begin
      borrow[j+1] = mask[j] ? approx_bout(x[j], y[j], borrow[j])
                            : exact_bout(x[j], y[j], borrow[j]);
    end
    // A set top bit means x already exceeds any DW-bit divisor.
    qs = ~borrow[DW] | x[DW];
    for (int unsigned j = 0; j < DW; j++) begin
      rout[j] = mask[j] ? approx_rout(x[j], y[j], borrow[j], qs)
                        : exact_rout(x[j], y[j], borrow[j], qs);
    end
  end

endmodule

// File: rtl/seq_approx_divider.sv
// Iterative restoring divider, one quotient bit per clock, with optional
// approximate cells in the low bits of the last APPROX_STAGES iterations.
// Optional feature macro: SEQ_DIV_APPROX_BYPASS_EN (adds approx_off port).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_valid/s_ready     operand handshake (ready only in IDLE)
//   dividend [2DW-1:0]  x
//   divisor  [DW-1:0]   y
//   m_valid/m_ready     result handshake
//   quotient, remainder results
//   dbz                 divisor was zero
//   ovf                 high dividend half >= divisor, quotient truncated
//   approx_off          (macro only) forces exact cells for the operation
module seq_approx_divider
  import seq_div_pkg::*;
#(
  parameter int DW            = 8,
  parameter int APPROX_STAGES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            dbz,
  output logic            ovf
`ifdef SEQ_DIV_APPROX_BYPASS_EN
  ,
  input  logic            approx_off
`endif
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   iter;
  logic [DW:0]     p;
  logic [DW-2:0]   lo;
  logic [DW-1:0]   y_q;
  logic [DW-1:0]   q_q, r_q;
  logic            dbz_q, ovf_q, mv_q;
  logic            last_iter;
  logic [31:0]     mask_full;
  logic [DW-1:0]   mask;
  logic            qs;
  logic [DW-1:0]   rout;
`ifdef SEQ_DIV_APPROX_BYPASS_EN
  logic            bypass_q;
`endif

  assign last_iter = (iter == CW'(DW - 1));

  always_comb begin
    mask_full = approx_mask(32'(iter), DW, APPROX_STAGES);
    mask      = mask_full[DW-1:0];
`ifdef SEQ_DIV_APPROX_BYPASS_EN
    if (bypass_q) mask = '0;
`endif
  end

  seq_div_row #(.DW(DW)) u_row (
    .x    (p),
    .y    (y_q),
    .mask (mask),
    .qs   (qs),
    .rout (rout)
  );

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = BUSY;
      end
      BUSY: if (last_iter) state_nxt = DONE;
      DONE: if (mv_q && m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      iter  <= '0;
      p     <= '0;
      lo    <= '0;
      y_q   <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
      mv_q  <= 1'b0;
`ifdef SEQ_DIV_APPROX_BYPASS_EN
      bypass_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (s_valid) begin
            y_q   <= divisor;
            lo    <= dividend[DW-2:0];
            p     <= dividend[2*DW-1:DW-1];
            iter  <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dbz_q <= (divisor == '0);
            ovf_q <= (dividend[2*DW-1:DW] >= divisor);
`ifdef SEQ_DIV_APPROX_BYPASS_EN
            bypass_q <= approx_off;
`endif
          end
        end
        BUSY: begin
          // Quotient fills MSB-first by shifting; it was cleared at accept.
          q_q  <= {q_q[DW-2:0], qs};
          p    <= {rout, lo[DW-2]};
          lo   <= lo << 1;
          iter <= iter + 1'b1;
          if (last_iter) r_q <= rout;
        end
        DONE: begin
          // First DONE cycle only raises m_valid; later cycles wait for m_ready.
          if (!mv_q) mv_q <= 1'b1;
          else if (m_ready) mv_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign m_valid   = mv_q;
  assign quotient  = q_q;
  assign remainder = r_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule
